// File: rtl/swd_host.sv
// SWD initiator: one DP/AP transaction or line reset at a time, SWCLK = i_clk / (2*CLK_DIV).
// Optional WAIT auto-retry is compiled in with `define SWD_HOST_RETRY_EN.
module swd_host #(
  parameter int CLK_DIV        = 4,
  parameter int IDLE_CYCLES    = 8,
  parameter int LINE_RESET_LEN = 56,
  parameter int MAX_RETRY      = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_apndp,
  input  logic        i_rnw,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_line_reset,
  output logic        o_rsp_valid,
  output logic [2:0]  o_ack,
  output logic [31:0] o_rdata,
  output logic        o_parity_err,
  output logic        o_busy,
  output logic        o_swclk,
  output logic        o_swdio_out,
  output logic        o_swdio_oe,
  input  logic        i_swdio_in
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_TRN1, S_ACK, S_RDATA, S_TRN2, S_WDATA, S_TAIL, S_LRESET, S_DONE
  } state_t;

  localparam logic [15:0] DIV_RISE = 16'(CLK_DIV - 1);
  localparam logic [15:0] DIV_LAST = 16'(2 * CLK_DIV - 1);
  localparam logic [7:0]  TAIL_END = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0]  LR_END   = 8'(LINE_RESET_LEN - 1);
  localparam logic [2:0]  ACK_OK   = 3'b001;

  state_t      state_q;
  logic [15:0] div_q;
  logic [7:0]  bit_q;
  logic [32:0] shreg_q;
  logic [32:0] rx_q;
  logic [7:0]  req_q;
  logic [31:0] wdata_q;
  logic        rnw_q;
  logic [1:0]  ack_sh_q;
  logic [2:0]  ack_rx_q;
  logic        swclk_q, out_q, oe_q, rsp_q, perr_q;
  logic [2:0]  ack_q;
  logic [31:0] rdata_q;
`ifdef SWD_HOST_RETRY_EN
  logic [7:0]  retry_q;
`endif

  logic       req_par;
  logic [7:0] req_byte;
  logic [2:0] ack_now;

  // Request byte LSB first: start, APnDP, RnW, A2, A3, parity, stop, park.
  assign req_par  = i_apndp ^ i_rnw ^ i_addr[0] ^ i_addr[1];
  assign req_byte = {1'b1, 1'b0, req_par, i_addr[1], i_addr[0], i_rnw, i_apndp, 1'b1};
  assign ack_now  = {i_swdio_in, ack_sh_q};

  // Handshake: a request or line reset is taken on the i_clk edge where it is
  // asserted while o_req_ready is high; o_rsp_valid is a single-cycle pulse.
  assign o_busy       = (state_q != S_IDLE);
  assign o_req_ready  = (state_q == S_IDLE);
  assign o_swclk      = swclk_q;
  assign o_swdio_out  = out_q;
  assign o_swdio_oe   = oe_q;
  assign o_rsp_valid  = rsp_q;
  assign o_ack        = ack_q;
  assign o_rdata      = rdata_q;
  assign o_parity_err = perr_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      rx_q     <= '0;
      req_q    <= '0;
      wdata_q  <= '0;
      rnw_q    <= 1'b0;
      ack_sh_q <= '0;
      ack_rx_q <= '0;
      swclk_q  <= 1'b0;
      out_q    <= 1'b0;
      oe_q     <= 1'b1;
      rsp_q    <= 1'b0;
      perr_q   <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
`ifdef SWD_HOST_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          div_q   <= '0;
          bit_q   <= '0;
          swclk_q <= 1'b0;
          if (i_line_reset) begin
            state_q  <= S_LRESET;
            out_q    <= 1'b1;
            oe_q     <= 1'b1;
            ack_rx_q <= '0;
          end else if (i_req_valid) begin
            state_q <= S_REQ;
            shreg_q <= {25'b0, req_byte};
            req_q   <= req_byte;
            wdata_q <= i_wdata;
            rnw_q   <= i_rnw;
            out_q   <= req_byte[0];
            oe_q    <= 1'b1;
            perr_q  <= 1'b0;
`ifdef SWD_HOST_RETRY_EN
            retry_q <= '0;
`endif
          end
        end
        S_DONE: begin
          rsp_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          if (div_q == DIV_RISE) swclk_q <= 1'b1;
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 16'd1;
          end else begin
            // End of a bit: target bits are sampled here, host bits set up for the next one.
            div_q   <= '0;
            swclk_q <= 1'b0;
            bit_q   <= bit_q + 8'd1;
            case (state_q)
              S_REQ: begin
                shreg_q <= shreg_q >> 1;
                out_q   <= shreg_q[1];
                if (bit_q == 8'd7) begin
                  state_q <= S_TRN1;
                  oe_q    <= 1'b0;
                  bit_q   <= '0;
                end
              end
              S_TRN1: begin
                state_q <= S_ACK;
                bit_q   <= '0;
              end
              S_ACK: begin
                ack_sh_q <= {i_swdio_in, ack_sh_q[1]};
                if (bit_q == 8'd2) begin
                  ack_rx_q <= ack_now;
                  bit_q    <= '0;
                  state_q  <= (ack_now == ACK_OK && rnw_q) ? S_RDATA : S_TRN2;
                end
              end
              S_RDATA: begin
                rx_q <= {i_swdio_in, rx_q[32:1]};
                if (bit_q == 8'd32) begin
                  perr_q  <= (^rx_q[32:1]) ^ i_swdio_in;
                  state_q <= S_TRN2;
                  bit_q   <= '0;
                end
              end
              S_TRN2: begin
                bit_q <= '0;
                oe_q  <= 1'b1;
                if (ack_rx_q == ACK_OK && !rnw_q) begin
                  state_q <= S_WDATA;
                  shreg_q <= {^wdata_q, wdata_q};
                  out_q   <= wdata_q[0];
                end else begin
                  state_q <= S_TAIL;
                  out_q   <= 1'b0;
                end
              end
              S_WDATA: begin
                shreg_q <= shreg_q >> 1;
                out_q   <= shreg_q[1];
                if (bit_q == 8'd32) begin
                  state_q <= S_TAIL;
                  out_q   <= 1'b0;
                  bit_q   <= '0;
                end
              end
              S_LRESET: begin
                if (bit_q == LR_END) begin
                  state_q <= S_TAIL;
                  out_q   <= 1'b0;
                  bit_q   <= '0;
                end
              end
              S_TAIL: begin
                if (bit_q == TAIL_END) begin
                  bit_q <= '0;
`ifdef SWD_HOST_RETRY_EN
                  if (ack_rx_q == 3'b010 && retry_q < 8'(MAX_RETRY)) begin
                    retry_q <= retry_q + 8'd1;
                    state_q <= S_REQ;
                    shreg_q <= {25'b0, req_q};
                    out_q   <= req_q[0];
                  end else begin
                    state_q <= S_DONE;
                    rsp_q   <= 1'b1;
                    ack_q   <= ack_rx_q;
                    if (ack_rx_q == ACK_OK && rnw_q) rdata_q <= rx_q[31:0];
                  end
`else
                  state_q <= S_DONE;
                  rsp_q   <= 1'b1;
                  ack_q   <= ack_rx_q;
                  if (ack_rx_q == ACK_OK && rnw_q) rdata_q <= rx_q[31:0];
`endif
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swd_host.sv
// Directed bench for swd_host with a bit-indexed SWD target model.
// Covers the WAIT retry path when built with SWD_HOST_RETRY_EN.
module tb_swd_host;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_apndp, i_rnw, i_line_reset;
  logic [1:0]  i_addr;
  logic [31:0] i_wdata;
  logic        i_swdio_in = 1'b0;
  logic        o_req_ready, o_rsp_valid, o_parity_err, o_busy;
  logic        o_swclk, o_swdio_out, o_swdio_oe;
  logic [2:0]  o_ack;
  logic [31:0] o_rdata;

  int total = 0;
  int bad   = 0;

  // Target model state: bits indexed by absolute SWCLK rising-edge number.
  logic tgt_bits [0:2047];
  logic host_out [0:2047];
  logic host_oe  [0:2047];
  int   edges      = 0;
  int   rsp_cnt    = 0;
  int   ready_viol = 0;
  logic lr_win     = 1'b0;

  always #5 clk = ~clk;

  swd_host dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_apndp     (i_apndp),
    .i_rnw       (i_rnw),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_line_reset(i_line_reset),
    .o_rsp_valid (o_rsp_valid),
    .o_ack       (o_ack),
    .o_rdata     (o_rdata),
    .o_parity_err(o_parity_err),
    .o_busy      (o_busy),
    .o_swclk     (o_swclk),
    .o_swdio_out (o_swdio_out),
    .o_swdio_oe  (o_swdio_oe),
    .i_swdio_in  (i_swdio_in)
  );

  always @(posedge o_swclk) begin
    if (edges < 2048) begin
      host_out[edges] = o_swdio_out;
      host_oe[edges]  = o_swdio_oe;
      i_swdio_in      = tgt_bits[edges];
    end
    edges = edges + 1;
  end

  always @(negedge clk) begin
    if (o_rsp_valid) rsp_cnt = rsp_cnt + 1;
    if (lr_win && o_req_ready) ready_viol = ready_viol + 1;
  end

  function automatic logic [7:0] host_byte(input int b);
    for (int i = 0; i < 8; i++) host_byte[i] = host_out[b + i];
  endfunction

  function automatic logic [31:0] host_word(input int b);
    for (int i = 0; i < 32; i++) host_word[i] = host_out[b + i];
  endfunction

  task automatic set_ack(input int b, input logic [2:0] ack);
    for (int i = 0; i < 3; i++) tgt_bits[b + 9 + i] = ack[i];
  endtask

  task automatic set_rdata(input int b, input logic [31:0] d, input logic par);
    for (int i = 0; i < 32; i++) tgt_bits[b + 12 + i] = d[i];
    tgt_bits[b + 44] = par;
  endtask

  task automatic issue(input logic ap, input logic rnw, input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_apndp     = ap;
    i_rnw       = rnw;
    i_addr      = a;
    i_wdata     = wd;
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: got no rsp_valid, want rsp_valid within 3000 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({o_swclk, o_swdio_oe, o_swdio_out, o_rsp_valid, o_busy, o_req_ready} !== 6'b010001) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 010001",
               {o_swclk, o_swdio_oe, o_swdio_out, o_rsp_valid, o_busy, o_req_ready});
    end
    total++;
    if ({o_ack, o_rdata, o_parity_err} !== 36'd0) begin
      bad++;
      $display("FAIL reset_data: got ack=%b rdata=%h perr=%b want 0", o_ack, o_rdata, o_parity_err);
    end
  endtask

  task automatic test_idcode_read();
    int b = edges;
    int rc = rsp_cnt;
    set_ack(b, 3'b001);
    set_rdata(b, 32'h0BB11477, 1'b1);
    issue(1'b0, 1'b1, 2'd0, 32'h0);
    wait_rsp("idcode");
    total++;
    if (o_ack !== 3'b001) begin bad++; $display("FAIL idcode_ack: got %b want 001", o_ack); end
    total++;
    if (o_rdata !== 32'h0BB11477) begin bad++; $display("FAIL idcode_rdata: got %h want 0bb11477", o_rdata); end
    total++;
    if (o_parity_err !== 1'b0) begin bad++; $display("FAIL idcode_perr: got %b want 0", o_parity_err); end
    total++;
    if (host_byte(b) !== 8'hA5) begin bad++; $display("FAIL idcode_req: got %h want a5", host_byte(b)); end
    @(negedge clk);
    total++;
    if (o_rsp_valid !== 1'b0 || rsp_cnt - rc != 1) begin
      bad++;
      $display("FAIL idcode_pulse: got rsp_valid=%b count=%0d want 0 and 1", o_rsp_valid, rsp_cnt - rc);
    end
    total++;
    if (edges - b != 54) begin bad++; $display("FAIL idcode_edges: got %0d want 54", edges - b); end
  endtask

  task automatic test_abort_write();
    int b = edges;
    int oe_bad = 0;
    set_ack(b, 3'b001);
    issue(1'b0, 1'b0, 2'd0, 32'h0000001E);
    wait_rsp("abort");
    total++;
    if (host_byte(b) !== 8'h81) begin bad++; $display("FAIL abort_req: got %h want 81", host_byte(b)); end
    total++;
    if (host_word(b + 13) !== 32'h1E || host_out[b + 45] !== 1'b0) begin
      bad++;
      $display("FAIL abort_wdata: got %h par %b want 0000001e par 0", host_word(b + 13), host_out[b + 45]);
    end
    for (int k = 0; k < 54; k++)
      if (host_oe[b + k] !== ((k >= 8 && k <= 12) ? 1'b0 : 1'b1)) oe_bad++;
    total++;
    if (oe_bad != 0) begin bad++; $display("FAIL abort_oe: got %0d wrong oe bits want 0", oe_bad); end
    total++;
    if (o_ack !== 3'b001 || o_rdata !== 32'h0BB11477) begin
      bad++;
      $display("FAIL abort_rsp: got ack=%b rdata=%h want 001 0bb11477", o_ack, o_rdata);
    end
    @(negedge clk);
    total++;
    if (edges - b != 54) begin bad++; $display("FAIL abort_edges: got %0d want 54", edges - b); end
  endtask

  task automatic test_wait();
    int b = edges;
    int rc = rsp_cnt;
`ifdef SWD_HOST_RETRY_EN
    int req_bad = 0;
    for (int n = 0; n < 3; n++) set_ack(b + 21 * n, 3'b010);
    set_ack(b + 63, 3'b001);
    set_rdata(b + 63, 32'h12345678, 1'b1);
    issue(1'b0, 1'b1, 2'd0, 32'h0);
    wait_rsp("retry");
    repeat (4) @(negedge clk);
    total++;
    if (o_ack !== 3'b001 || o_rdata !== 32'h12345678) begin
      bad++;
      $display("FAIL retry_rsp: got ack=%b rdata=%h want 001 12345678", o_ack, o_rdata);
    end
    total++;
    if (rsp_cnt - rc != 1) begin bad++; $display("FAIL retry_pulses: got %0d want 1", rsp_cnt - rc); end
    for (int n = 0; n < 4; n++) if (host_byte(b + 21 * n) !== 8'hA5) req_bad++;
    total++;
    if (req_bad != 0 || edges - b != 117) begin
      bad++;
      $display("FAIL retry_phases: got %0d bad requests, %0d edges want 0 and 117", req_bad, edges - b);
    end
`else
    set_ack(b, 3'b010);
    issue(1'b0, 1'b1, 2'd0, 32'h0);
    wait_rsp("wait");
    total++;
    if (o_ack !== 3'b010) begin bad++; $display("FAIL wait_ack: got %b want 010", o_ack); end
    total++;
    if (o_rdata !== 32'h0BB11477) begin bad++; $display("FAIL wait_rdata: got %h want 0bb11477", o_rdata); end
    repeat (4) @(negedge clk);
    total++;
    if (edges - b != 21 || rsp_cnt - rc != 1) begin
      bad++;
      $display("FAIL wait_edges: got %0d edges %0d pulses want 21 and 1", edges - b, rsp_cnt - rc);
    end
`endif
  endtask

  task automatic test_parity_err();
    int b = edges;
    set_ack(b, 3'b001);
    set_rdata(b, 32'h00000001, 1'b0);
    issue(1'b1, 1'b1, 2'd1, 32'h0);
    wait_rsp("parity");
    total++;
    if (host_byte(b) !== 8'hAF) begin bad++; $display("FAIL parity_req: got %h want af", host_byte(b)); end
    total++;
    if (o_parity_err !== 1'b1 || o_rdata !== 32'h1 || o_ack !== 3'b001) begin
      bad++;
      $display("FAIL parity_rsp: got perr=%b rdata=%h ack=%b want 1 00000001 001",
               o_parity_err, o_rdata, o_ack);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_line_reset();
    int b = edges;
    int rc = rsp_cnt;
    int bit_bad = 0;
    @(negedge clk);
    i_line_reset = 1'b1;
    i_req_valid  = 1'b1;
    i_apndp = 1'b0; i_rnw = 1'b1; i_addr = 2'd0;
    @(negedge clk);
    i_line_reset = 1'b0;
    i_req_valid  = 1'b0;
    lr_win = 1'b1;
    wait_rsp("lreset");
    lr_win = 1'b0;
    total++;
    if (o_ack !== 3'b000) begin bad++; $display("FAIL lreset_ack: got %b want 000", o_ack); end
    for (int k = 0; k < 64; k++)
      if (host_out[b + k] !== (k < 56 ? 1'b1 : 1'b0) || host_oe[b + k] !== 1'b1) bit_bad++;
    total++;
    if (bit_bad != 0) begin bad++; $display("FAIL lreset_bits: got %0d wrong bits want 0", bit_bad); end
    total++;
    if (ready_viol != 0) begin bad++; $display("FAIL lreset_ready: got %0d ready cycles want 0", ready_viol); end
    repeat (20) @(negedge clk);
    total++;
    if (edges - b != 64 || o_busy !== 1'b0 || rsp_cnt - rc != 1) begin
      bad++;
      $display("FAIL lreset_consumed: got %0d edges busy=%b %0d pulses want 64 0 1",
               edges - b, o_busy, rsp_cnt - rc);
    end
  endtask

  task automatic test_reset_mid();
    int b = edges;
    int rc;
    bit reached = 1'b0;
    set_ack(b, 3'b001);
    set_rdata(b, 32'h55AA55AA, 1'b0);
    issue(1'b0, 1'b1, 2'd0, 32'h0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (edges - b >= 20) begin
        reached = 1'b1;
        break;
      end
    end
    total++;
    if (!reached) begin bad++; $display("FAIL midrst_reach: got %0d edges want 20", edges - b); end
    rc = rsp_cnt;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({o_swclk, o_swdio_oe, o_swdio_out, o_busy, o_req_ready} !== 5'b01001) begin
      bad++;
      $display("FAIL midrst_async: got %b want 01001",
               {o_swclk, o_swdio_oe, o_swdio_out, o_busy, o_req_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (rsp_cnt != rc || o_ack !== 3'b000 || o_rdata !== 32'h0) begin
      bad++;
      $display("FAIL midrst_norsp: got %0d pulses ack=%b rdata=%h want 0 000 0",
               rsp_cnt - rc, o_ack, o_rdata);
    end
    b = edges;
    set_ack(b, 3'b001);
    set_rdata(b, 32'hCAFEF00D, 1'b0);
    issue(1'b0, 1'b1, 2'd0, 32'h0);
    wait_rsp("after_rst");
    total++;
    if (o_ack !== 3'b001 || o_rdata !== 32'hCAFEF00D || o_parity_err !== 1'b0) begin
      bad++;
      $display("FAIL after_rst_rsp: got ack=%b rdata=%h perr=%b want 001 cafef00d 0",
               o_ack, o_rdata, o_parity_err);
    end
    @(negedge clk);
    total++;
    if (edges - b != 54) begin bad++; $display("FAIL after_rst_edges: got %0d want 54", edges - b); end
  endtask

  initial begin
    rst_n = 1'b0;
    i_req_valid = 1'b0; i_apndp = 1'b0; i_rnw = 1'b0; i_addr = 2'd0;
    i_wdata = 32'h0; i_line_reset = 1'b0;
    for (int i = 0; i < 2048; i++) tgt_bits[i] = 1'b0;
    test_reset();
    test_idcode_read();
    test_abort_write();
    test_wait();
    test_parity_err();
    test_line_reset();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/swd_host.md
Name: swd_host

Overview:
- SWD initiator (debug-probe side) for the Cortex-M0 debug port.
- Generates SWCLK and drives/samples SWDIO to run single DP/AP register transactions per ADIv5 SW-DP: request, turnaround, ACK, data, parity.
- Also issues line-reset sequences.
- Used for self-hosted debug and for bench-driving the core's SWCLKTCK/SWDITMS/SWDO/SWDOEN pins; top level owns the inout pad.

Parameters:
- CLK_DIV, 4: i_clk cycles per SWCLK half-period (>=1).
- IDLE_CYCLES, 8: SWCLK cycles with SWDIO=0 appended after every transaction and line reset.
- LINE_RESET_LEN, 56: SWCLK cycles with SWDIO=1 in a line reset (>=50).
- MAX_RETRY, 15: WAIT retry limit; used only with the optional feature.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-low reset
- i_req_valid  in  1  transaction request
- o_req_ready  out  1  high only in IDLE
- i_apndp  in  1  0=DP, 1=AP
- i_rnw  in  1  1=read
- i_addr  in  2  A[3:2]
- i_wdata  in  32  write data
- i_line_reset  in  1  line-reset request, sampled in IDLE
- o_rsp_valid  out  1  one-cycle completion pulse
- o_ack  out  3  received ACK, first-received bit in [0]
- o_rdata  out  32  read data
- o_parity_err  out  1  read-data parity mismatch
- o_busy  out  1  state != IDLE
- o_swclk  out  1  SWCLK
- o_swdio_out  out  1  SWDIO drive value
- o_swdio_oe  out  1  1=host drives SWDIO
- i_swdio_in  in  1  SWDIO pad input (top synchronises if needed)

Behaviour:
- Clock and reset: one clock i_clk. i_reset is asynchronous, active-low.
- Reset values: state IDLE, o_swclk=0, o_swdio_oe=1, o_swdio_out=0, o_rsp_valid=0, o_ack=0, o_rdata=0, o_parity_err=0, o_busy=0, o_req_ready=1. Reset mid-transaction aborts immediately to these values; no response is produced.
- Bit period: 2*CLK_DIV i_clk cycles. o_swclk is low for the first CLK_DIV, high for the second. o_swclk stays 0 in IDLE.
- Host-driven bits change at the start of the low phase (the falling edge); the target samples on the rising edge.
- Target-driven bits: i_swdio_in is sampled on the last i_clk of the high phase.
- All fields are sent and received LSB first.
- Handshake: accept when i_req_valid && o_req_ready; the request fields and i_wdata are captured in that cycle. i_line_reset has priority when both are asserted in IDLE. Requests arriving while busy are ignored (ready=0).
- Request byte: start=1, APnDP, RnW, A2, A3, parity = XOR of those four, stop=0, park=1.
- States: IDLE -> REQ(8) -> TRN1(1, oe=0) -> ACK(3, oe=0), then branch:
  - ACK=3'b001 (OK), read: RDATA(33: 32 data + parity, oe=0) -> TRN2(1, oe=0) -> TAIL.
  - ACK=3'b001 (OK), write: TRN2(1, oe=0) -> WDATA(33, oe=1: data + even-parity bit = XOR of data) -> TAIL.
  - Any other ACK (WAIT 3'b010, FAULT 3'b100, protocol error e.g. 3'b111): TRN2 -> TAIL, no data phase. o_rdata is unchanged.
- TAIL: IDLE_CYCLES bits with oe=1, out=0 -> DONE. DONE lasts one i_clk: o_rsp_valid=1 -> IDLE.
- Bit-count totals (SWCLK rising edges): read OK 46+IDLE_CYCLES; write OK 46+IDLE_CYCLES; non-OK 13+IDLE_CYCLES.
- o_parity_err = XOR(32 data bits) != received parity bit. Updated only on read OK, cleared at each accept.
- o_ack and o_rdata hold their value until the next completion.
- LRESET: LINE_RESET_LEN bits of out=1, then TAIL, then DONE with o_rsp_valid=1 and o_ack=0.

Optional Feature:
- Macro: SWD_HOST_RETRY_EN.
- When defined:
  - ACK=WAIT goes through TRN2 and TAIL, then re-enters REQ with the same captured request, up to MAX_RETRY re-issues.
  - o_rsp_valid fires only for the final attempt: the first non-WAIT ACK, or WAIT after MAX_RETRY retries.
  - Retry counter is 4+ bits wide and cleared at accept.
- When not defined: WAIT completes immediately like FAULT, and MAX_RETRY is ignored.

Test Plan:
- DP IDCODE read (apndp=0, rnw=1, addr=0) with the target model returning OK and 0x0BB11477, parity 1: request bits equal 0xA5 LSB-first; o_ack=3'b001, o_rdata=0x0BB11477, o_parity_err=0; 54 SWCLK rising edges (46 + 8 idle), o_rsp_valid for one cycle.
- DP ABORT write (apndp=0, rnw=0, addr=0) of wdata=0x0000001E with target OK: request bits equal 0x81; 32 data bits 0x1E LSB-first followed by parity bit 0; oe low exactly during TRN1, ACK and TRN2.
- Target returns WAIT with the macro undefined: o_ack=3'b010, no data phase, 21 SWCLK edges, o_rdata unchanged. With SWD_HOST_RETRY_EN and WAIT x3 then OK: 4 request phases and a single o_rsp_valid with ack=OK.
- Read of 0x00000001 with the target's parity bit forced to 0: o_parity_err=1, o_rdata=0x00000001.
- i_line_reset and i_req_valid asserted together in IDLE: 56 bits of SWDIO=1 followed by 8 zeros; response ack=0; o_req_ready=0 throughout; the request is not consumed.
- i_reset low during the RDATA phase: o_swclk=0, oe=1, out=0 and o_busy=0 asynchronously; no o_rsp_valid; the next request completes normally.
